ifu_fetch: RTL

- Instruction fetch unit that sits directly upstream of the IF/ID pipeline register.
- Owns the fetch PC and issues in-order requests to the instruction ROM bus, using a req/gnt request phase and an rvalid response phase.
- Buffers returned instructions in a small FIFO and presents them with their PCs to IF/ID.
- Handles pipeline hold and jump redirection, including discarding wrong-path responses still in flight.

---
 rtl/ifu_fetch.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding the IF/ID pipeline register.
//
// Owns the fetch PC and issues in-order word fetches on a req/gnt + rvalid
// ROM bus. Returned instructions land in a small FIFO together with the PC
// they were fetched from. The FIFO head is presented to IF/ID.
//
// Ports
//   clk           core clock, rising edge
//   rstn          synchronous active-low reset
//   hold_flag_i   IF/ID stall; blocks the pop
//   jump_flag_i   redirect request; flushes and refetches from jump_addr_i
//   jump_addr_i   redirect target (low two bits ignored)
//   rom_req_o     fetch request valid
//   rom_addr_o    fetch address (word aligned)
//   rom_gnt_i     request accepted when rom_req_o=1
//   rom_rvalid_i  response valid, in request order, >=1 cycle after grant
//   rom_rdata_i   response instruction
//   inst_o        instruction to IF/ID (NOP when empty)
//   addr_o        PC of inst_o (0 when empty)
//   inst_valid_o  inst_o/addr_o carry a real instruction

module ifu_fetch #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        hold_flag_i,
  input  logic        jump_flag_i,
  input  logic [31:0] jump_addr_i,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_gnt_i,
  input  logic        rom_rvalid_i,
  input  logic [31:0] rom_rdata_i,
  output logic [31:0] inst_o,
  output logic [31:0] addr_o,
  output logic        inst_valid_o
);

  // FIFO_DEPTH is 2 or 4, so pointers wrap naturally at their width.
  localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
  localparam int CW = PW + 1;
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [CW:0]   DEPTH_C = (CW+1)'(FIFO_DEPTH);

  // Sequential state
  logic          rstn_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] discard_q, discard_d;

  logic [31:0]   fifo_inst_q [FIFO_DEPTH];
  logic [31:0]   fifo_inst_d [FIFO_DEPTH];
  logic [31:0]   fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]   fifo_pc_d   [FIFO_DEPTH];
  logic [PW-1:0] fifo_rd_q, fifo_rd_d;
  logic [PW-1:0] fifo_wr_q, fifo_wr_d;
  logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

  // PCs of granted, not-yet-returned requests on the current path
  logic [31:0]   pcq_q [FIFO_DEPTH];
  logic [31:0]   pcq_d [FIFO_DEPTH];
  logic [PW-1:0] pcq_rd_q, pcq_rd_d;
  logic [PW-1:0] pcq_wr_q, pcq_wr_d;

  // Combinational helpers
  logic        fifo_empty;
  logic [CW:0] credit_used;
  logic        handshake;
  logic        drop;
  logic        push;
  logic        pop;
  logic [31:0] jump_target;

  always_comb begin
    fifo_empty  = (fifo_cnt_q == '0);
    // Credits count occupancy before this cycle's pop, so a response can
    // always be accepted without looking at hold/pop in the same cycle.
    credit_used = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
    rom_req_o   = rstn_q & ~jump_flag_i & (credit_used < DEPTH_C);
    rom_addr_o  = fetch_pc_q;
    handshake   = rom_req_o & rom_gnt_i;
    drop        = rom_rvalid_i & (discard_q != '0);
    push        = rom_rvalid_i & (discard_q == '0) & ~jump_flag_i;
    pop         = ~fifo_empty & ~hold_flag_i & ~jump_flag_i;
    jump_target = jump_addr_i & 32'hFFFF_FFFC;

    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    fifo_inst_d   = fifo_inst_q;
    fifo_pc_d     = fifo_pc_q;
    fifo_rd_d     = fifo_rd_q;
    fifo_wr_d     = fifo_wr_q;
    fifo_cnt_d    = fifo_cnt_q;
    pcq_d         = pcq_q;
    pcq_rd_d      = pcq_rd_q;
    pcq_wr_d      = pcq_wr_q;

    if (handshake) begin
      fetch_pc_d      = fetch_pc_q + 32'd4;
      pcq_d[pcq_wr_q] = fetch_pc_q;
      pcq_wr_d        = pcq_wr_q + 1'b1;
    end

    unique case ({handshake, rom_rvalid_i})
      2'b10:   outstanding_d = outstanding_q + 1'b1;
      2'b01:   outstanding_d = outstanding_q - 1'b1;
      default: outstanding_d = outstanding_q;
    endcase

    if (drop) begin
      discard_d = discard_q - 1'b1;
    end

    if (push) begin
      fifo_inst_d[fifo_wr_q] = rom_rdata_i;
      fifo_pc_d[fifo_wr_q]   = pcq_q[pcq_rd_q];
      fifo_wr_d              = fifo_wr_q + 1'b1;
      pcq_rd_d               = pcq_rd_q + 1'b1;
    end

    if (pop) begin
      fifo_rd_d = fifo_rd_q + 1'b1;
    end

    fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(pop);

    // Redirect: everything still in flight belongs to the old path. The
    // outstanding count already includes any earlier pending discards, and
    // a response landing this cycle is consumed here.
    if (jump_flag_i) begin
      fetch_pc_d = jump_target;
      fifo_rd_d  = '0;
      fifo_wr_d  = '0;
      fifo_cnt_d = '0;
      pcq_rd_d   = '0;
      pcq_wr_d   = '0;
      discard_d  = outstanding_q - CW'(rom_rvalid_i);
    end

    if (fifo_empty || jump_flag_i) begin
      inst_o       = NOP;
      addr_o       = 32'h0;
      inst_valid_o = 1'b0;
    end else begin
      inst_o       = fifo_inst_q[fifo_rd_q];
      addr_o       = fifo_pc_q[fifo_rd_q];
      inst_valid_o = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rstn_q        <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      fifo_rd_q     <= '0;
      fifo_wr_q     <= '0;
      fifo_cnt_q    <= '0;
      pcq_rd_q      <= '0;
      pcq_wr_q      <= '0;
    end else begin
      rstn_q        <= 1'b1;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      fifo_rd_q     <= fifo_rd_d;
      fifo_wr_q     <= fifo_wr_d;
      fifo_cnt_q    <= fifo_cnt_d;
      pcq_rd_q      <= pcq_rd_d;
      pcq_wr_q      <= pcq_wr_d;
    end
  end

  // Storage arrays need no reset: they are only read behind the counters.
  always_ff @(posedge clk) begin
    fifo_inst_q <= fifo_inst_d;
    fifo_pc_q   <= fifo_pc_d;
    pcq_q       <= pcq_d;
  end

endmodule
